// File: rtl/dmem_arb.sv
// Two-requester data-memory arbiter. A CPU load/store unit (r0) and a
// DMA/debug port (r1) share one single-ported memory. Ties are broken
// round-robin, and each access runs to completion before the next grant.
// Stores complete one cycle after the grant. Loads complete two cycles
// after the grant and return raw memory data.
module dmem_arb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              r0_req_i,
  input  logic              r0_wr_i,
  input  logic [1:0]        r0_rwtype_i,
  input  logic [ADDR_W-1:0] r0_addr_i,
  input  logic [DATA_W-1:0] r0_wdata_i,
  output logic              r0_gnt_o,
  output logic              r0_done_o,
  output logic [DATA_W-1:0] r0_rdata_o,
  input  logic              r1_req_i,
  input  logic              r1_wr_i,
  input  logic [1:0]        r1_rwtype_i,
  input  logic [ADDR_W-1:0] r1_addr_i,
  input  logic [DATA_W-1:0] r1_wdata_i,
  output logic              r1_gnt_o,
  output logic              r1_done_o,
  output logic [DATA_W-1:0] r1_rdata_o,
  output logic              mem_en_o,
  output logic              mem_wr_o,
  output logic [1:0]        mem_rwtype_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                last_gnt;
  logic                grant;
  logic                grant_sel;
  logic                done;
  logic                done_ok;
  logic                mem_en;
  logic                owner;
  logic                acc_wr;
  logic [1:0]          acc_rwtype;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_wdata;

  // Next-state and strobe decode. A grant is only possible from IDLE with reset low.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_sel = 1'b0;
    done      = 1'b0;
    mem_en    = 1'b0;
    case (state)
      IDLE: begin
        if (!rst_i && (r0_req_i || r1_req_i)) begin
          grant = 1'b1;
          // On contention the requester that was not served last wins.
          if (r0_req_i && r1_req_i) grant_sel = ~last_gnt;
          else                      grant_sel = r1_req_i;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        mem_en = 1'b1;
        if (acc_wr) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and round-robin history. After reset, last_gnt=1 so r0 wins the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
    end else begin
      state <= state_nxt;
      if (grant) last_gnt <= grant_sel;
    end
  end

  // Capture the winning request on grant so later requester activity cannot disturb it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner      <= 1'b0;
      acc_wr     <= 1'b0;
      acc_rwtype <= 2'b00;
      acc_addr   <= '0;
      acc_wdata  <= '0;
    end else if (grant) begin
      owner      <= grant_sel;
      acc_wr     <= grant_sel ? r1_wr_i     : r0_wr_i;
      acc_rwtype <= grant_sel ? r1_rwtype_i : r0_rwtype_i;
      acc_addr   <= grant_sel ? r1_addr_i   : r0_addr_i;
      acc_wdata  <= grant_sel ? r1_wdata_i  : r0_wdata_i;
    end
  end

  // A reset arriving mid-access suppresses the completion pulse in that cycle.
  assign done_ok = done & ~rst_i;

  assign r0_gnt_o  = grant & ~grant_sel;
  assign r1_gnt_o  = grant &  grant_sel;
  assign r0_done_o = done_ok & ~owner;
  assign r1_done_o = done_ok &  owner;

  // Load data is only forwarded in RESP, which is reached by loads only.
  assign r0_rdata_o = (done_ok && !owner && state == RESP) ? mem_rdata_i : '0;
  assign r1_rdata_o = (done_ok &&  owner && state == RESP) ? mem_rdata_i : '0;

  // Memory bus is held at zero whenever no access is being strobed.
  assign mem_en_o     = mem_en;
  assign mem_wr_o     = mem_en & acc_wr;
  assign mem_rwtype_o = mem_en ? acc_rwtype : 2'b00;
  assign mem_addr_o   = mem_en ? acc_addr   : '0;
  assign mem_wdata_o  = mem_en ? acc_wdata  : '0;

endmodule

// File: tb/tb_dmem_arb.sv
// Randomized scoreboard bench for dmem_arb. The stimulus process keeps a
// transaction-level model of the arbiter: the bus is free from the cycle
// after the previous completion, and ties go to the requester not served
// last. From this model it queues the expected grant, memory strobe and
// completion events. A separate monitor matches DUT outputs against those
// events.
module tb_dmem_arb;

  localparam int NCYC = 4000;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        r0_req_i, r0_wr_i, r1_req_i, r1_wr_i;
  logic [1:0]  r0_rwtype_i, r1_rwtype_i;
  logic [11:0] r0_addr_i, r1_addr_i;
  logic [31:0] r0_wdata_i, r1_wdata_i;
  logic        r0_gnt_o, r0_done_o, r1_gnt_o, r1_done_o;
  logic [31:0] r0_rdata_o, r1_rdata_o;
  logic        mem_en_o, mem_wr_o;
  logic [1:0]  mem_rwtype_o;
  logic [11:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i = 32'h0;

  always #5 clk = ~clk;

  dmem_arb dut (
    .clk_i(clk), .rst_i(rst_i),
    .r0_req_i(r0_req_i), .r0_wr_i(r0_wr_i), .r0_rwtype_i(r0_rwtype_i),
    .r0_addr_i(r0_addr_i), .r0_wdata_i(r0_wdata_i),
    .r0_gnt_o(r0_gnt_o), .r0_done_o(r0_done_o), .r0_rdata_o(r0_rdata_o),
    .r1_req_i(r1_req_i), .r1_wr_i(r1_wr_i), .r1_rwtype_i(r1_rwtype_i),
    .r1_addr_i(r1_addr_i), .r1_wdata_i(r1_wdata_i),
    .r1_gnt_o(r1_gnt_o), .r1_done_o(r1_done_o), .r1_rdata_o(r1_rdata_o),
    .mem_en_o(mem_en_o), .mem_wr_o(mem_wr_o), .mem_rwtype_o(mem_rwtype_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  typedef struct {
    int          cyc;
    logic        owner;
    logic        wr;
    logic [1:0]  rw;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } ev_t;

  ev_t gq[$];
  ev_t mq[$];
  ev_t dq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Memory contents are a fixed function of the address.
  function automatic logic [31:0] rdv(input logic [11:0] a);
    return {a, 8'h5A, a} ^ 32'h1357_9BDF;
  endfunction

  // Memory stub: read data appears one cycle after a read strobe; garbage otherwise.
  always @(posedge clk)
    mem_rdata_i <= (mem_en_o && !mem_wr_o) ? rdv(mem_addr_o) : $urandom();

  task automatic chk(input bit ok, input string msg);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s", msg);
    end
  endtask

  // Monitor: compares every DUT output against queued expectations.
  always @(negedge clk) begin
    ev_t e;
    logic g, d;
    logic [31:0] rd;
    bit ok;
    if (cyc >= 1) begin
      while (gq.size() > 0 && gq[0].cyc < cyc) begin
        chk(1'b0, $sformatf("gnt_missing cycle %0d: got no grant, required r%0d_gnt=1", gq[0].cyc, gq[0].owner));
        gq.delete(0);
      end
      while (mq.size() > 0 && mq[0].cyc < cyc) begin
        chk(1'b0, $sformatf("mem_missing cycle %0d: got mem_en=0, required 1", mq[0].cyc));
        mq.delete(0);
      end
      while (dq.size() > 0 && dq[0].cyc < cyc) begin
        chk(1'b0, $sformatf("done_missing cycle %0d: got r%0d_done=0, required 1", dq[0].cyc, dq[0].owner));
        dq.delete(0);
      end
      for (int n = 0; n < 2; n++) begin
        g = (n == 1) ? r1_gnt_o : r0_gnt_o;
        if (g) begin
          ok = gq.size() > 0 && gq[0].cyc == cyc && gq[0].owner == n[0];
          chk(ok, $sformatf("gnt_unexpected cycle %0d: got r%0d_gnt=1, required 0", cyc, n));
          if (ok) gq.delete(0);
        end
      end
      if (mem_en_o) begin
        if (mq.size() > 0 && mq[0].cyc == cyc) begin
          e = mq[0];
          mq.delete(0);
          chk({mem_wr_o, mem_rwtype_o, mem_addr_o, mem_wdata_o} == {e.wr, e.rw, e.addr, e.wdata},
              $sformatf("mem_access cycle %0d: got wr=%0d rw=%0d addr=%h wdata=%h, required wr=%0d rw=%0d addr=%h wdata=%h",
                        cyc, mem_wr_o, mem_rwtype_o, mem_addr_o, mem_wdata_o, e.wr, e.rw, e.addr, e.wdata));
        end else begin
          chk(1'b0, $sformatf("mem_unexpected cycle %0d: got mem_en=1, required 0", cyc));
        end
      end else begin
        chk({mem_wr_o, mem_rwtype_o, mem_addr_o, mem_wdata_o} == '0,
            $sformatf("mem_idle_zero cycle %0d: got wr=%0d rw=%0d addr=%h wdata=%h, required all 0",
                      cyc, mem_wr_o, mem_rwtype_o, mem_addr_o, mem_wdata_o));
      end
      for (int n = 0; n < 2; n++) begin
        d  = (n == 1) ? r1_done_o  : r0_done_o;
        rd = (n == 1) ? r1_rdata_o : r0_rdata_o;
        if (d) begin
          if (dq.size() > 0 && dq[0].cyc == cyc && dq[0].owner == n[0]) begin
            e = dq[0];
            dq.delete(0);
            chk(rd == e.rdata, $sformatf("done_rdata cycle %0d r%0d: got %h, required %h", cyc, n, rd, e.rdata));
          end else begin
            chk(1'b0, $sformatf("done_unexpected cycle %0d: got r%0d_done=1, required 0", cyc, n));
          end
        end else begin
          chk(rd == 32'h0, $sformatf("rdata_idle_zero cycle %0d r%0d: got %h, required 0", cyc, n, rd));
        end
      end
    end
  end

  // Stimulus and reference model.
  bit          pend[2];
  bit          gprev[2];
  logic        wr_s[2];
  logic [1:0]  rw_s[2];
  logic [11:0] ad_s[2];
  logic [31:0] wd_s[2];

  initial begin
    int   free_at;
    bit   last;
    int   rst_left;
    bit   drain;
    logic w;
    ev_t  e;
    free_at  = 0;
    last     = 1'b1;
    rst_left = 0;
    rst_i = 1'b1;
    r0_req_i = 1'b0; r0_wr_i = 1'b0; r0_rwtype_i = 2'b00; r0_addr_i = '0; r0_wdata_i = '0;
    r1_req_i = 1'b0; r1_wr_i = 1'b0; r1_rwtype_i = 2'b00; r1_addr_i = '0; r1_wdata_i = '0;
    for (int n = 0; n < 2; n++) begin
      pend[n] = 1'b0;
      gprev[n] = 1'b0;
    end

    for (int k = 0; k < NCYC; k++) begin
      @(posedge clk);
      cyc++;
      #1;
      drain = (k >= NCYC - 20);
      if (k < 2) begin
        rst_i = 1'b1;
      end else if (rst_left > 0) begin
        rst_i = 1'b1;
        rst_left--;
      end else if (!drain && $urandom_range(0, 49) == 0) begin
        rst_i = 1'b1;
        rst_left = $urandom_range(0, 1);
      end else begin
        rst_i = 1'b0;
      end

      // A granted request is retired; a fresh one may follow at once with req held high.
      for (int n = 0; n < 2; n++) begin
        if (gprev[n]) pend[n] = 1'b0;
        gprev[n] = 1'b0;
        if (!pend[n]) begin
          wr_s[n] = 1'($urandom_range(0, 1));
          rw_s[n] = 2'($urandom_range(0, 3));
          ad_s[n] = 12'($urandom());
          wd_s[n] = $urandom();
          if (!drain && $urandom_range(0, 2) == 0) pend[n] = 1'b1;
        end
      end
      r0_req_i = pend[0]; r0_wr_i = wr_s[0]; r0_rwtype_i = rw_s[0]; r0_addr_i = ad_s[0]; r0_wdata_i = wd_s[0];
      r1_req_i = pend[1]; r1_wr_i = wr_s[1]; r1_rwtype_i = rw_s[1]; r1_addr_i = ad_s[1]; r1_wdata_i = wd_s[1];

      if (rst_i) begin
        // Reset aborts the access in flight; a strobe already shown this cycle stays.
        free_at = cyc + 1;
        last = 1'b1;
        while (dq.size() > 0 && dq[dq.size()-1].cyc >= cyc) dq.delete(dq.size() - 1);
        while (mq.size() > 0 && mq[mq.size()-1].cyc > cyc) mq.delete(mq.size() - 1);
      end else if (cyc >= free_at && (pend[0] || pend[1])) begin
        w = (pend[0] && pend[1]) ? ~last : pend[1];
        e.owner = w;
        e.wr    = wr_s[w];
        e.rw    = rw_s[w];
        e.addr  = ad_s[w];
        e.wdata = wd_s[w];
        e.rdata = wr_s[w] ? 32'h0 : rdv(ad_s[w]);
        e.cyc = cyc;
        gq.push_back(e);
        e.cyc = cyc + 1;
        mq.push_back(e);
        e.cyc = wr_s[w] ? cyc + 1 : cyc + 2;
        dq.push_back(e);
        last = w;
        free_at = wr_s[w] ? cyc + 2 : cyc + 3;
        gprev[w] = 1'b1;
      end
    end

    @(negedge clk);
    #1;
    chk(gq.size() == 0 && mq.size() == 0 && dq.size() == 0,
        $sformatf("queues_drained: got gnt=%0d mem=%0d done=%0d pending, required 0", gq.size(), mq.size(), dq.size()));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
